// File: rtl/alien_fire_scheduler_if.sv
// alien_fire_scheduler_if
//   Bundles the signals between the alien shot scheduler and its surroundings:
//   frame timing, the `random` latch block, the alien matrix and the
//   alien-shot object.
//
//   enable        game running; low parks the scheduler in IDLE
//   startOfFrame  one-cycle pulse per video frame
//   rand_in       dout of the `random` block
//   rand_req      strobe to random.rise
//   alive_cols    bit c set = column c still has an alive alien
//   shot_busy     an alien shot is already in flight
//   fire          one-cycle launch strobe
//   fire_col      column of the launch, holds after fire
//
//   master : the scheduler side
//   slave  : the environment side (timing, random, matrix, shot object)
`timescale 1ns/1ps
interface alien_fire_scheduler_if #(
  parameter int SIZE_BITS = 8,
  parameter int COLS      = 11,
  parameter int COL_BITS  = 4
);
  logic                 enable;
  logic                 startOfFrame;
  logic [SIZE_BITS-1:0] rand_in;
  logic                 rand_req;
  logic [COLS-1:0]      alive_cols;
  logic                 shot_busy;
  logic                 fire;
  logic [COL_BITS-1:0]  fire_col;

  modport master (
    input  enable, startOfFrame, rand_in, alive_cols, shot_busy,
    output rand_req, fire, fire_col
  );

  modport slave (
    output enable, startOfFrame, rand_in, alive_cols, shot_busy,
    input  rand_req, fire, fire_col
  );
endinterface

// File: rtl/alien_fire_scheduler.sv
// alien_fire_scheduler
//   Decides when, and from which alien column, the next enemy shot is
//   launched. Each shot costs two samples from the `random` block: one sets
//   the delay in frames, the other picks the starting column. The delay is
//   counted down on startOfFrame, then the column is reduced modulo COLS by
//   repeated subtraction and checked against alive_cols before firing.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    alien_fire_scheduler_if.master (see interface file)
//
//   Build option:
//     SCHED_SKIP_DEAD_EN  when defined, SCAN walks forward (with wrap-around)
//                         from the picked column until it finds an alive one,
//                         giving up after COLS columns. When undefined, a
//                         dead picked column simply restarts the delay.
`timescale 1ns/1ps
module alien_fire_scheduler #(
  parameter int SIZE_BITS   = 8,
  parameter int COLS        = 11,
  parameter int COL_BITS    = 4,
  parameter int MIN_DELAY   = 8,
  parameter int DELAY_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alien_fire_scheduler_if.master bus
);

  // Delay counter sized for the largest MIN_DELAY + (rand >> DELAY_SHIFT).
  localparam int MAX_DELAY = MIN_DELAY + ((2**SIZE_BITS - 1) >> DELAY_SHIFT);
  localparam int DLY_BITS  = $clog2(MAX_DELAY + 1);
  // idx must hold a raw random value before it is reduced modulo COLS.
  localparam int IDX_BITS  = (SIZE_BITS > COL_BITS) ? SIZE_BITS : COL_BITS;

  localparam logic [IDX_BITS-1:0] COLS_IDX = IDX_BITS'(COLS);
  localparam logic [DLY_BITS-1:0] MIN_DLY  = DLY_BITS'(MIN_DELAY);

`ifdef SCHED_SKIP_DEAD_EN
  localparam int SCAN_BITS = $clog2(COLS + 1);
  localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(COLS - 1);
  localparam logic [SCAN_BITS-1:0] LAST_SCAN = SCAN_BITS'(COLS - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, REQ_DLY, WAIT_DLY, COUNT, REQ_COL, WAIT_COL, MOD, SCAN, FIRE
  } state_t;

  state_t              r_state, w_stateNext;
  logic                r_reqSecond, w_reqSecondNext;
  logic [DLY_BITS-1:0] r_delayCnt, w_delayCntNext;
  logic [IDX_BITS-1:0] r_idx, w_idxNext;
  logic [COL_BITS-1:0] r_fireCol, w_fireColNext;
`ifdef SCHED_SKIP_DEAD_EN
  logic [SCAN_BITS-1:0] r_scanCnt, w_scanCntNext;
`endif

  logic [COL_BITS-1:0] w_idxCol;
  logic                w_colAlive;
  logic [DLY_BITS-1:0] w_randDelay;
  logic                w_randReq;
  logic                w_fire;

  // In SCAN idx is always below COLS, so its low bits are a valid column.
  assign w_idxCol    = r_idx[COL_BITS-1:0];
  assign w_colAlive  = bus.alive_cols[w_idxCol];
  assign w_randDelay = MIN_DLY + DLY_BITS'(bus.rand_in >> DELAY_SHIFT);

  assign bus.rand_req = w_randReq;
  assign bus.fire     = w_fire;
  assign bus.fire_col = r_fireCol;

  // Next-state and output logic. Every register holds by default; the
  // request states use r_reqSecond to stretch rand_req over two cycles.
  // Dropping enable overrides everything: back to IDLE with both strobes
  // low, while fire_col keeps its last launched column.
  always_comb begin
    w_stateNext     = r_state;
    w_reqSecondNext = 1'b0;
    w_delayCntNext  = r_delayCnt;
    w_idxNext       = r_idx;
    w_fireColNext   = r_fireCol;
`ifdef SCHED_SKIP_DEAD_EN
    w_scanCntNext   = r_scanCnt;
`endif
    w_randReq       = 1'b0;
    w_fire          = 1'b0;

    case (r_state)
      IDLE: begin
        w_stateNext = REQ_DLY;
      end
      REQ_DLY: begin
        w_randReq = 1'b1;
        if (r_reqSecond) w_stateNext = WAIT_DLY;
        else             w_reqSecondNext = 1'b1;
      end
      WAIT_DLY: begin
        w_delayCntNext = w_randDelay;
        w_stateNext    = COUNT;
      end
      COUNT: begin
        // At zero the count is frozen; only shot_busy going low releases it.
        if (r_delayCnt == '0) begin
          if (!bus.shot_busy) w_stateNext = REQ_COL;
        end else if (bus.startOfFrame) begin
          w_delayCntNext = r_delayCnt - DLY_BITS'(1);
        end
      end
      REQ_COL: begin
        w_randReq = 1'b1;
        if (r_reqSecond) w_stateNext = WAIT_COL;
        else             w_reqSecondNext = 1'b1;
      end
      WAIT_COL: begin
        w_idxNext   = IDX_BITS'(bus.rand_in);
        w_stateNext = MOD;
      end
      MOD: begin
        // Modulo by repeated subtraction, one step per cycle.
        if (r_idx >= COLS_IDX) begin
          w_idxNext = r_idx - COLS_IDX;
        end else begin
`ifdef SCHED_SKIP_DEAD_EN
          w_scanCntNext = '0;
`endif
          w_stateNext = SCAN;
        end
      end
      SCAN: begin
`ifdef SCHED_SKIP_DEAD_EN
        if (w_colAlive) begin
          w_fireColNext = w_idxCol;
          w_stateNext   = FIRE;
        end else if (r_scanCnt == LAST_SCAN) begin
          w_stateNext = REQ_DLY;
        end else begin
          w_idxNext     = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_BITS'(1);
          w_scanCntNext = r_scanCnt + SCAN_BITS'(1);
        end
`else
        if (w_colAlive) begin
          w_fireColNext = w_idxCol;
          w_stateNext   = FIRE;
        end else begin
          w_stateNext = REQ_DLY;
        end
`endif
      end
      FIRE: begin
        w_fire      = 1'b1;
        w_stateNext = REQ_DLY;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (!bus.enable) begin
      w_stateNext     = IDLE;
      w_reqSecondNext = 1'b0;
      w_fireColNext   = r_fireCol;
      w_randReq       = 1'b0;
      w_fire          = 1'b0;
    end
  end

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_reqSecond <= 1'b0;
      r_delayCnt  <= '0;
      r_idx       <= '0;
      r_fireCol   <= '0;
`ifdef SCHED_SKIP_DEAD_EN
      r_scanCnt   <= '0;
`endif
    end else begin
      r_state     <= w_stateNext;
      r_reqSecond <= w_reqSecondNext;
      r_delayCnt  <= w_delayCntNext;
      r_idx       <= w_idxNext;
      r_fireCol   <= w_fireColNext;
`ifdef SCHED_SKIP_DEAD_EN
      r_scanCnt   <= w_scanCntNext;
`endif
    end
  end

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// tb_alien_fire_scheduler
//   Self-checking bench for alien_fire_scheduler. The bench plays the part
//   of the `random` block: on each rising rand_req it latches the next value
//   from randQ onto rand_in. Expected launches (column and latency from the
//   column request) are queued in sbQ and matched when fire appears.
//   Expectations for dead-column cases follow SCHED_SKIP_DEAD_EN.
`timescale 1ns/1ps
module tb_alien_fire_scheduler;

  localparam int SIZE_BITS   = 8;
  localparam int COLS        = 11;
  localparam int COL_BITS    = 4;
  localparam int MIN_DELAY   = 8;
  localparam int DELAY_SHIFT = 4;

  typedef struct {
    logic [7:0]  randDly;
    logic [7:0]  randCol;
    logic [10:0] alive;
    int          expFire;
    int          expCol;
    int          expLat;
  } vec_t;

  typedef struct {
    int col;
    int lat;
  } sb_t;

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;

  logic [7:0] randQ[$];
  sb_t        sbQ[$];

  int   cyc       = 0;
  int   reqRise   = 0;
  int   riseCyc   = 0;
  int   fireCount = 0;
  logic prevReq   = 1'b0;
  logic prevFire  = 1'b0;

  int expReq[4] = '{0, 1, 1, 0};

  always #5 clk = ~clk;

  alien_fire_scheduler_if #(
    .SIZE_BITS(SIZE_BITS), .COLS(COLS), .COL_BITS(COL_BITS)
  ) bus ();

  alien_fire_scheduler #(
    .SIZE_BITS(SIZE_BITS), .COLS(COLS), .COL_BITS(COL_BITS),
    .MIN_DELAY(MIN_DELAY), .DELAY_SHIFT(DELAY_SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Random-latch model and fire scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (bus.rand_req && !prevReq) begin
      reqRise++;
      riseCyc = cyc;
      if (randQ.size() > 0) bus.rand_in = randQ.pop_front();
      else                  bus.rand_in = 8'h00;
    end
    if (bus.fire) begin
      fireCount++;
      checkOutput("fire_width", int'(prevFire), 0);
      checkOutput("fire_expected", int'(sbQ.size() > 0), 1);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("fire_col", int'(bus.fire_col), e.col);
        checkOutput("fire_latency", cyc - riseCyc, e.lat);
      end
    end
    prevReq  = bus.rand_req;
    prevFire = bus.fire;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic waitRise(input int target, input int budget, input string name);
    int n = 0;
    while (reqRise < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, int'(reqRise >= target), 1);
  endtask

  task automatic doReset();
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.shot_busy    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int   pulses;
    int   rb;
    int   fb;
    sb_t  e;
    doReset();
    randQ.delete();
    randQ.push_back(v.randDly);
    randQ.push_back(v.randCol);
    bus.alive_cols = v.alive;
    if (v.expFire != 0) begin
      e.col = v.expCol;
      e.lat = v.expLat;
      sbQ.push_back(e);
    end
    rb = reqRise;
    fb = fireCount;
    bus.enable = 1'b1;
    waitRise(rb + 1, 10, $sformatf("v%0d_dly_req", idx));
    repeat (4) tick();
    pulses = 0;
    while (reqRise < rb + 2 && pulses < 64) begin
      pulse();
      pulses++;
    end
    checkOutput($sformatf("v%0d_delay_frames", idx), pulses,
                MIN_DELAY + (int'(v.randDly) >> DELAY_SHIFT));
    waitRise(rb + 3, 100, $sformatf("v%0d_next_dly_req", idx));
    bus.enable = 1'b0;
    tick();
    tick();
    checkOutput($sformatf("v%0d_fire_count", idx), fireCount - fb, v.expFire);
    checkOutput($sformatf("v%0d_sb_drained", idx), sbQ.size(), 0);
    sbQ.delete();
    if (v.expFire != 0)
      checkOutput($sformatf("v%0d_fire_col_hold", idx), int'(bus.fire_col), v.expCol);
  endtask

  // Reset has priority over enable, then rand_req appears one cycle after enable.
  task automatic resetSequence();
    reset      = 1'b1;
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_rand_req", int'(bus.rand_req), 0);
      checkOutput("rst_fire", int'(bus.fire), 0);
      checkOutput("rst_fire_col", int'(bus.fire_col), 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("en_rand_req_c%0d", i + 1), int'(bus.rand_req), expReq[i]);
      tick();
    end
    bus.enable = 1'b0;
    tick();
  endtask

  // Delay expires while a shot is in flight: hold, ignore frames, then go.
  task automatic busySequence();
    int  rb;
    int  fb;
    sb_t e;
    doReset();
    randQ.delete();
    randQ.push_back(8'h00);
    randQ.push_back(8'h21);
    bus.alive_cols = '1;
    bus.shot_busy  = 1'b1;
    rb = reqRise;
    fb = fireCount;
    bus.enable = 1'b1;
    waitRise(rb + 1, 10, "busy_dly_req");
    repeat (4) tick();
    repeat (MIN_DELAY) pulse();
    repeat (17) pulse();
    checkOutput("busy_hold_req", reqRise, rb + 1);
    checkOutput("busy_no_fire", fireCount, fb);
    e.col = 0;
    e.lat = 8;
    sbQ.push_back(e);
    bus.shot_busy = 1'b0;
    waitRise(rb + 2, 4, "busy_release");
    waitRise(rb + 3, 60, "busy_next_req");
    bus.enable = 1'b0;
    tick();
    tick();
    checkOutput("busy_fire_count", fireCount - fb, 1);
    checkOutput("busy_sb_drained", sbQ.size(), 0);
    sbQ.delete();
  endtask

  // Drop enable in the middle of a long MOD, then re-enable.
  task automatic enableDropSequence();
    int rb;
    int fb;
    doReset();
    randQ.delete();
    randQ.push_back(8'h00);
    randQ.push_back(8'hFF);
    bus.alive_cols = '1;
    rb = reqRise;
    fb = fireCount;
    bus.enable = 1'b1;
    waitRise(rb + 1, 10, "drop_dly_req");
    repeat (4) tick();
    for (int i = 0; i < 64 && reqRise < rb + 2; i++) pulse();
    checkOutput("drop_col_req", reqRise, rb + 2);
    repeat (3) tick();
    bus.enable = 1'b0;
    tick();
    checkOutput("drop_rand_req", int'(bus.rand_req), 0);
    checkOutput("drop_fire", int'(bus.fire), 0);
    repeat (40) tick();
    checkOutput("drop_no_fire", fireCount - fb, 0);
    checkOutput("drop_no_req", reqRise, rb + 2);
    randQ.delete();
    randQ.push_back(8'h00);
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reen_rand_req_c%0d", i + 1), int'(bus.rand_req), expReq[i]);
      tick();
    end
    bus.enable = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{8'h35, 8'h35, 11'h7FF, 1, 9, 9};
    vecs[1] = '{8'h00, 8'h00, 11'h7FF, 1, 0, 5};
    vecs[2] = '{8'hFF, 8'hFF, 11'h7FF, 1, 2, 28};
    vecs[3] = '{8'h12, 8'h0A, 11'h7FF, 1, 10, 5};
    vecs[4] = '{8'h40, 8'h0B, 11'h7FF, 1, 0, 6};
`ifdef SCHED_SKIP_DEAD_EN
    vecs[5] = '{8'h35, 8'h35, 11'b00111111111, 1, 0, 11};
    vecs[7] = '{8'h00, 8'h05, 11'b00000000100, 1, 2, 13};
`else
    vecs[5] = '{8'h35, 8'h35, 11'b00111111111, 0, 0, 0};
    vecs[7] = '{8'h00, 8'h05, 11'b00000000100, 0, 0, 0};
`endif
    vecs[6] = '{8'h20, 8'h03, 11'h000, 0, 0, 0};
    vecs[8] = '{8'h50, 8'h07, 11'b00010000000, 1, 7, 5};

    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.alive_cols   = '0;
    bus.shot_busy    = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);
    resetSequence();
    busySequence();
    enableDropSequence();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alien_fire_scheduler.md
# alien_fire_scheduler

Decides when and from which alien column the next enemy shot is launched. It is the requesting side of the `random` latch block: it drives that block's `rise` input with a strobe, then samples its `dout` twice per shot, once for the delay and once for the column. It counts the delay down in frames and issues a one-cycle fire strobe with a live column index to the alien-shot object. It sits between the frame timing logic and the alien matrix / alien-shot modules.

## Interface
- SIZE_BITS, 8, width of random value from `random`
- COLS, 11, number of alien columns
- COL_BITS, 4, width of column index (≥ clog2(COLS))
- MIN_DELAY, 8, minimum frames between shots
- DELAY_SHIFT, 4, random value right-shift applied before adding to MIN_DELAY

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; low forces IDLE
- startOfFrame  in  1  one-cycle pulse per video frame
- rand_in  in  SIZE_BITS  `dout` of `random`
- rand_req  out  1  strobe to `random.rise`
- alive_cols  in  COLS  bit c = column c has at least one alive alien
- shot_busy  in  1  an alien shot is already in flight
- fire  out  1  one-cycle launch strobe
- fire_col  out  COL_BITS  column of the launch; valid when fire=1, holds afterwards

## Operation
- States: IDLE, REQ_DLY, WAIT_DLY, COUNT, REQ_COL, WAIT_COL, MOD, SCAN, FIRE.
- IDLE: outputs low. enable=1 → REQ_DLY.
- REQ_DLY / REQ_COL: rand_req=1 for exactly 2 cycles, then → WAIT_DLY / WAIT_COL.
- WAIT_DLY / WAIT_COL: rand_req=0 for 1 cycle; rand_in is sampled at the end of this cycle.
- WAIT_DLY sample: delay_cnt ← MIN_DELAY + (rand_in >> DELAY_SHIFT). delay_cnt is wide enough to hold no overflow. → COUNT.
- COUNT: each startOfFrame decrements delay_cnt.
  - Leave COUNT → REQ_COL when delay_cnt==0 and shot_busy==0.
  - While delay_cnt==0 and shot_busy==1, hold; startOfFrame is ignored.
- WAIT_COL sample: idx ← rand_in. → MOD.
- MOD: one iteration per cycle.
  - If idx ≥ COLS: idx ← idx − COLS.
  - Else → SCAN.
  - MOD therefore takes floor(rand_in/COLS)+1 cycles.
- SCAN: one column per cycle, with scan counter n starting at 0.
  - If alive_cols[idx]: fire_col ← idx, → FIRE.
  - Else idx ← (idx==COLS−1) ? 0 : idx+1, and n++.
  - When n reaches COLS (alive_cols==0): → REQ_DLY, no fire.
- FIRE: fire=1 for 1 cycle. → REQ_DLY.
- enable=0 in any state: next state IDLE, rand_req=0, any pending shot is dropped, fire_col unchanged.
- alive_cols is sampled live each SCAN cycle. A change in alive_cols mid-scan affects only the columns not yet checked.

## Timing
- Reset values: state IDLE, rand_req 0, fire 0, fire_col 0, delay_cnt 0.
- Reset has priority over enable. Reset mid-operation aborts the current state next cycle, with no fire.
- Enable to first rand_req: 1 cycle (IDLE → REQ_DLY).
- From leaving COUNT to fire: 2 + 1 + (floor(rand/COLS)+1) + (scan steps+1) + 0 cycles. fire is asserted in the FIRE cycle.
- rand_req pulses are separated by ≥1 low cycle, so `random` always sees a fresh rising edge.
- At most one fire per delay period. fire is never asserted while shot_busy was 1 in the COUNT exit cycle.

## Configuration
- SCHED_SKIP_DEAD_EN defined: SCAN behaves as described above and searches forward with wrap-around for an alive column.
- SCHED_SKIP_DEAD_EN undefined: SCAN lasts exactly 1 cycle.
  - If alive_cols[idx]: → FIRE.
  - Else → REQ_DLY with no fire; the delay is restarted with a new random value.

## Test plan
- Reset held 3 cycles, then enable=1: all outputs 0 during reset; rand_req high exactly cycles 2–3 after enable.
- Delay: rand_in=0x35 at WAIT_DLY sample → delay_cnt=8+3=11; after 11 startOfFrame pulses, rand_req reasserts.
- Column: rand_in=0x35 at WAIT_COL sample, alive_cols all ones → MOD 5 cycles, fire=1 one cycle with fire_col=9.
- Skip (SCHED_SKIP_DEAD_EN): rand 0x35, alive_cols=11'b00111111111 → fire_col=0 after 3 SCAN cycles. Without the macro: no fire, returns to REQ_DLY.
- alive_cols=0 → no fire, REQ_DLY after 11 SCAN steps. shot_busy=1 at delay 0 for 50 cycles → no fire until it drops.
- enable dropped during MOD → IDLE next cycle, no fire, rand_req 0. Re-enable restarts from REQ_DLY.
